// File: rtl/turn_pkg.sv
// Shared types and width helpers for the turn scheduler.
// The optional strike/forfeit logic is enabled by defining TURN_CTRL_STRIKE_EN.
package turn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RUN,
        SWITCH,
        DONE
    } turn_state_e;

    localparam int DEF_NUM_PLAYERS   = 2;
    localparam int DEF_TIMEOUT_TICKS = 15;
    localparam int DEF_MAX_STRIKES   = 3;

    // Player index width; a single-bit index is kept even for degenerate sizes.
    function automatic int playerWidth(input int numPlayers);
        return (numPlayers < 2) ? 1 : $clog2(numPlayers);
    endfunction

    // Width needed to hold 0..maxValue inclusive.
    function automatic int timeWidth(input int maxValue);
        return (maxValue < 1) ? 1 : $clog2(maxValue + 1);
    endfunction

endpackage

// File: rtl/turn_timer.sv
// Loadable turn-timeout down-counter that saturates at zero.
// Used by turn_ctrl; unaffected by TURN_CTRL_STRIKE_EN.
module turn_timer
    import turn_pkg::*;
#(
    parameter int LOAD_VALUE = DEF_TIMEOUT_TICKS,
    parameter int WIDTH      = timeWidth(DEF_TIMEOUT_TICKS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             tick_i,
    output logic             zero_o,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = WIDTH'(LOAD_VALUE);
        end else if (tick_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o  = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/turn_ctrl.sv
// Round-robin turn scheduler sharing one timeout counter between all players.
// Define TURN_CTRL_STRIKE_EN to enable per-player strike counting and forfeit.
module turn_ctrl
    import turn_pkg::*;
#(
    parameter  int NUM_PLAYERS   = DEF_NUM_PLAYERS,
    parameter  int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
    parameter  int MAX_STRIKES   = DEF_MAX_STRIKES,
    localparam int PW            = playerWidth(NUM_PLAYERS),
    localparam int TW            = timeWidth(TIMEOUT_TICKS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          tick_i,
    input  logic          move_done_i,
    input  logic          game_over_i,
    output logic [PW-1:0] turn_player_o,
    output logic          turn_active_o,
    output logic [TW-1:0] time_left_o,
    output logic          timeout_pulse_o,
    output logic          forfeit_o
);

    turn_state_e   state_q, state_d;
    logic [PW-1:0] turnPlayer_q, turnPlayer_d;
    logic          turnActive_q, turnActive_d;
    logic          timeoutPulse_q, timeoutPulse_d;
    logic          timerLoad;
    logic          timerDec;
    logic          timerZero;

`ifdef TURN_CTRL_STRIKE_EN
    localparam int SW = timeWidth(MAX_STRIKES);
    logic [SW-1:0] strikes_q [NUM_PLAYERS];
    logic [SW-1:0] strikes_d [NUM_PLAYERS];
    logic          forfeit_q, forfeit_d;
`endif

    turn_timer #(
        .LOAD_VALUE (TIMEOUT_TICKS),
        .WIDTH      (TW)
    ) u_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (timerLoad),
        .tick_i  (timerDec),
        .zero_o  (timerZero),
        .count_o (time_left_o)
    );

    always_comb begin
        state_d        = state_q;
        turnPlayer_d   = turnPlayer_q;
        timeoutPulse_d = 1'b0;
        timerLoad      = 1'b0;
        timerDec       = 1'b0;
`ifdef TURN_CTRL_STRIKE_EN
        forfeit_d = forfeit_q;
        strikes_d = strikes_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d      = ARM;
                    turnPlayer_d = '0;
                end
            end

            ARM: begin
                if (game_over_i) begin
                    state_d = DONE;
                end else begin
                    timerLoad = 1'b1;
                    state_d   = RUN;
                end
            end

            // game_over beats a move, and a move beats a timeout on the same tick.
            RUN: begin
                if (game_over_i) begin
                    state_d = DONE;
                end else if (move_done_i) begin
                    state_d = SWITCH;
`ifdef TURN_CTRL_STRIKE_EN
                    strikes_d[turnPlayer_q] = '0;
`endif
                end else if (tick_i && timerZero) begin
                    timeoutPulse_d = 1'b1;
`ifdef TURN_CTRL_STRIKE_EN
                    if (strikes_q[turnPlayer_q] == SW'(MAX_STRIKES - 1)) begin
                        strikes_d[turnPlayer_q] = SW'(MAX_STRIKES);
                        forfeit_d               = 1'b1;
                        state_d                 = DONE;
                    end else begin
                        strikes_d[turnPlayer_q] = strikes_q[turnPlayer_q] + SW'(1);
                        state_d                 = SWITCH;
                    end
`else
                    state_d = SWITCH;
`endif
                end else if (tick_i) begin
                    timerDec = 1'b1;
                end
            end

            SWITCH: begin
                if (game_over_i) begin
                    state_d = DONE;
                end else begin
                    state_d = ARM;
                    if (turnPlayer_q == PW'(NUM_PLAYERS - 1)) begin
                        turnPlayer_d = '0;
                    end else begin
                        turnPlayer_d = turnPlayer_q + PW'(1);
                    end
                end
            end

            DONE: begin
                if (start_i) begin
                    state_d      = ARM;
                    turnPlayer_d = '0;
`ifdef TURN_CTRL_STRIKE_EN
                    forfeit_d = 1'b0;
                    for (int i = 0; i < NUM_PLAYERS; i++) begin
                        strikes_d[i] = '0;
                    end
`endif
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        turnActive_d = (state_d == RUN);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            turnPlayer_q   <= '0;
            turnActive_q   <= 1'b0;
            timeoutPulse_q <= 1'b0;
`ifdef TURN_CTRL_STRIKE_EN
            forfeit_q <= 1'b0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                strikes_q[i] <= '0;
            end
`endif
        end else begin
            state_q        <= state_d;
            turnPlayer_q   <= turnPlayer_d;
            turnActive_q   <= turnActive_d;
            timeoutPulse_q <= timeoutPulse_d;
`ifdef TURN_CTRL_STRIKE_EN
            forfeit_q <= forfeit_d;
            strikes_q <= strikes_d;
`endif
        end
    end

    assign turn_player_o   = turnPlayer_q;
    assign turn_active_o   = turnActive_q;
    assign timeout_pulse_o = timeoutPulse_q;

`ifdef TURN_CTRL_STRIKE_EN
    assign forfeit_o = forfeit_q;
`else
    assign forfeit_o = 1'b0;
`endif

endmodule

// File: tb/tb_turn_ctrl.sv
// Self-checking bench for turn_ctrl: a cycle-level behavioural model is compared
// every cycle, and directed scenarios pin key values; honours TURN_CTRL_STRIKE_EN.
module tb_turn_ctrl;

    localparam int NP = 3;
    localparam int TT = 3;
    localparam int MS = 2;
    localparam int PW = $clog2(NP);
    localparam int TW = $clog2(TT + 1);

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          start    = 1'b0;
    logic          tick     = 1'b0;
    logic          moveDone = 1'b0;
    logic          gameOver = 1'b0;
    logic [PW-1:0] turnPlayer;
    logic          turnActive;
    logic [TW-1:0] timeLeft;
    logic          timeoutPulse;
    logic          forfeit;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    turn_ctrl #(
        .NUM_PLAYERS   (NP),
        .TIMEOUT_TICKS (TT),
        .MAX_STRIKES   (MS)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start),
        .tick_i          (tick),
        .move_done_i     (moveDone),
        .game_over_i     (gameOver),
        .turn_player_o   (turnPlayer),
        .turn_active_o   (turnActive),
        .time_left_o     (timeLeft),
        .timeout_pulse_o (timeoutPulse),
        .forfeit_o       (forfeit)
    );

    // Behavioural model: the game is waiting, preparing a turn, playing a turn,
    // handing over, or finished; outputs follow directly from those rules.
    localparam int WAITING  = 0;
    localparam int PREPARE  = 1;
    localparam int PLAYING  = 2;
    localparam int HANDOVER = 3;
    localparam int FINISHED = 4;

    int mPhase   = WAITING;
    int mPlayer  = 0;
    int mTime    = 0;
    int mActive  = 0;
    int mPulse   = 0;
    int mForfeit = 0;
    int mStrikes [NP];

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelStep();
        mPulse = 0;
        if (rst) begin
            mPhase   = WAITING;
            mPlayer  = 0;
            mTime    = 0;
            mForfeit = 0;
            foreach (mStrikes[i]) mStrikes[i] = 0;
        end else if (mPhase == WAITING) begin
            if (start) begin
                mPhase  = PREPARE;
                mPlayer = 0;
            end
        end else if (mPhase == PREPARE) begin
            if (gameOver) mPhase = FINISHED;
            else begin
                mTime  = TT;
                mPhase = PLAYING;
            end
        end else if (mPhase == PLAYING) begin
            if (gameOver) mPhase = FINISHED;
            else if (moveDone) begin
                mStrikes[mPlayer] = 0;
                mPhase = HANDOVER;
            end else if (tick && mTime == 0) begin
                mPulse = 1;
`ifdef TURN_CTRL_STRIKE_EN
                mStrikes[mPlayer] = mStrikes[mPlayer] + 1;
                if (mStrikes[mPlayer] >= MS) begin
                    mForfeit = 1;
                    mPhase   = FINISHED;
                end else mPhase = HANDOVER;
`else
                mPhase = HANDOVER;
`endif
            end else if (tick) begin
                mTime = mTime - 1;
            end
        end else if (mPhase == HANDOVER) begin
            if (gameOver) mPhase = FINISHED;
            else begin
                mPlayer = (mPlayer + 1) % NP;
                mPhase  = PREPARE;
            end
        end else begin
            if (start) begin
                mPhase   = PREPARE;
                mPlayer  = 0;
                mForfeit = 0;
                foreach (mStrikes[i]) mStrikes[i] = 0;
            end
        end
        mActive = (mPhase == PLAYING) ? 1 : 0;
    endtask

    task automatic checkOutput();
        compare("model turn_player", 32'(turnPlayer), 32'(mPlayer));
        compare("model turn_active", 32'(turnActive), 32'(mActive));
        compare("model time_left", 32'(timeLeft), 32'(mTime));
        compare("model timeout_pulse", 32'(timeoutPulse), 32'(mPulse));
        compare("model forfeit", 32'(forfeit), 32'(mForfeit));
    endtask

    // Model advances on every edge; DUT outputs are compared 1 time unit later.
    always @(posedge clk) begin
        modelStep();
        #1;
        checkOutput();
    end

    // Drive one cycle of inputs, then return at the following falling edge.
    task automatic applyStimulus(input logic s, input logic t, input logic m,
                                 input logic g, input logic r);
        start    = s;
        tick     = t;
        moveDone = m;
        gameOver = g;
        rst      = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        compare("reset turn_player", 32'(turnPlayer), 32'd0);
        compare("reset turn_active", 32'(turnActive), 32'd0);
        compare("reset time_left", 32'(timeLeft), 32'd0);
        compare("reset forfeit", 32'(forfeit), 32'd0);

        // Full timed-out turn with a tick every fourth cycle.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        compare("arm inactive", 32'(turnActive), 32'd0);
        idle(1);
        compare("run time_left", 32'(timeLeft), 32'd3);
        compare("run active", 32'(turnActive), 32'd1);
        for (int k = 0; k < 4; k++) begin
            idle(3);
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            if (k < 3) compare("countdown", 32'(timeLeft), 32'(2 - k));
        end
        compare("timeout pulse", 32'(timeoutPulse), 32'd1);
        compare("timeout inactive", 32'(turnActive), 32'd0);
        idle(1);
        compare("pulse one cycle", 32'(timeoutPulse), 32'd0);
        compare("rotate to 1", 32'(turnPlayer), 32'd1);
        idle(1);
        compare("reload time", 32'(timeLeft), 32'd3);

        // Moves rotate through all players and wrap.
        for (int p = 0; p < 3; p++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            compare("move no pulse", 32'(timeoutPulse), 32'd0);
            idle(2);
            compare("move rotation", 32'(turnPlayer), 32'((p + 2) % 3));
        end

        // Move and tick at zero together count as a move.
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        compare("time at zero", 32'(timeLeft), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        compare("move beats timeout", 32'(timeoutPulse), 32'd0);
        idle(1);
        compare("single advance", 32'(turnPlayer), 32'd2);
        idle(1);

        // game_over with move ends the game without rotating.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        compare("done inactive", 32'(turnActive), 32'd0);
        compare("done player held", 32'(turnPlayer), 32'd2);
        idle(2);
        compare("done time held", 32'(timeLeft), 32'd2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        compare("restart player", 32'(turnPlayer), 32'd0);
        idle(1);
        compare("restart time", 32'(timeLeft), 32'd3);

        // Reset mid-turn, then inputs other than start are ignored.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        compare("pre-reset player", 32'(turnPlayer), 32'd1);
        compare("pre-reset time", 32'(timeLeft), 32'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        compare("mid reset player", 32'(turnPlayer), 32'd0);
        compare("mid reset time", 32'(timeLeft), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        compare("idle ignores inputs", 32'(turnActive), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);

        // Player 0 times out twice in a row across other players' moves.
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        compare("first strike pulse", 32'(timeoutPulse), 32'd1);
        idle(2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        compare("back to player 0", 32'(turnPlayer), 32'd0);
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        compare("second timeout pulse", 32'(timeoutPulse), 32'd1);
`ifdef TURN_CTRL_STRIKE_EN
        compare("forfeit set", 32'(forfeit), 32'd1);
        idle(1);
        compare("forfeit player", 32'(turnPlayer), 32'd0);
        compare("forfeit done", 32'(turnActive), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        compare("forfeit cleared", 32'(forfeit), 32'd0);
`else
        compare("no forfeit", 32'(forfeit), 32'd0);
        idle(1);
        compare("timeout rotates", 32'(turnPlayer), 32'd1);
`endif
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
